// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: one shared single-digit BCD add stage, LSD first,
// decimal carry rippled through a register, start/busy/done handshake.
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  carry_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  carry,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ADD  = 1'b1;

  logic [0:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_res;
  logic          r_c;
  logic          r_inv;
  logic [IW-1:0] r_idx;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_sum;
  logic          r_carry;
  logic          r_invalid;

  logic [4:0]    w_s;
  logic [4:0]    w_s_adj;
  logic [3:0]    w_digit;
  logic          w_c_next;
  logic [W-1:0]  w_res_next;
  logic          w_last;

  function automatic logic any_non_bcd(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // Operands shift right each ADD cycle, so the active digit is always bits [3:0].
  // Single-digit BCD add stage with decimal correction.
  always_comb begin
    w_s      = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0000, r_c};
    w_s_adj  = w_s + 5'd6;
    w_digit  = w_s[3:0];
    w_c_next = 1'b0;
    if (w_s > 5'd9) begin
      w_digit  = w_s_adj[3:0];
      w_c_next = 1'b1;
    end else begin
      w_digit  = w_s[3:0];
      w_c_next = 1'b0;
    end
  end

  // Result digits enter at the top and shift down, landing in place after DIGITS steps.
  generate
    if (DIGITS == 1) begin : g_one
      assign w_res_next = w_digit;
    end else begin : g_many
      assign w_res_next = {w_digit, r_res[W-1:4]};
    end
  endgenerate

  assign w_last = (r_idx == IW'(DIGITS - 1));

  // Sequencer: accept in IDLE, one digit per clock in ADD, publish on the last digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_c       <= 1'b0;
      r_inv     <= 1'b0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_invalid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= carry_in;
            r_inv   <= any_non_bcd(a) | any_non_bcd(b);
            r_res   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ADD: begin
          r_a   <= r_a >> 3'd4;
          r_b   <= r_b >> 3'd4;
          r_c   <= w_c_next;
          r_res <= w_res_next;
          r_idx <= r_idx + IW'(1);
          if (w_last) begin
            r_sum     <= w_res_next;
            r_carry   <= w_c_next;
            r_invalid <= r_inv;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_idx     <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_state <= S_ADD;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign sum     = r_sum;
  assign carry   = r_carry;
  assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for bcd_serial_adder_ctrl (DIGITS=4) with hand-computed BCD results.
module tb_bcd_serial_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        carry;
  logic        invalid;

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_sum;
  logic        prev_carry;
  logic        prev_inv;
  int          lat;
  int          done_cnt;

  bcd_serial_adder_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .carry_in(carry_in),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .invalid(invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one add, check hold-during-busy, latency and results, and that done is one cycle.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic [15:0] es, input logic ec, input logic ei);
    a = ta; b = tb_; carry_in = tc; start = 1'b1;
    tick();
    start = 1'b0; a = 16'h0000; b = 16'h0000; carry_in = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
      chk({tag, "_hold_sum"}, {16'd0, sum}, {16'd0, prev_sum});
      chk({tag, "_hold_carry"}, {31'd0, carry}, {31'd0, prev_carry});
      chk({tag, "_hold_inv"}, {31'd0, invalid}, {31'd0, prev_inv});
    end
    chk({tag, "_latency"}, lat, 32'd4);
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    chk({tag, "_carry"}, {31'd0, carry}, {31'd0, ec});
    chk({tag, "_invalid"}, {31'd0, invalid}, {31'd0, ei});
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    prev_sum = es; prev_carry = ec; prev_inv = ei;
    tick();
    chk({tag, "_done_once"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = 16'h0000; b = 16'h0000; carry_in = 1'b0;
    prev_sum = 16'h0000; prev_carry = 1'b0; prev_inv = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_invalid", {31'd0, invalid}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("t1", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("t2a", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t2b", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);
    run_op("t3a", 16'h000E, 16'h0003, 1'b0, 16'h0017, 1'b0, 1'b1);
    run_op("t3b", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
    run_op("t3c", 16'h000F, 16'h000F, 1'b1, 16'h0015, 1'b0, 1'b1);
    run_op("t3d", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Start ignored while busy, then back-to-back start in the done cycle.
    a = 16'h1234; b = 16'h5678; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_not_done_e3", {31'd0, done}, 32'd0);
    chk("t4_hold_sum", {16'd0, sum}, 32'h0007);
    tick();
    chk("t4_done1", {31'd0, done}, 32'd1);
    chk("t4_sum1", {16'd0, sum}, 32'h6912);
    chk("t4_carry1", {31'd0, carry}, 32'd0);
    a = 16'h0001; b = 16'h0002; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_b2b_busy", {31'd0, busy}, 32'd1);
    chk("t4_b2b_no_double_done", {31'd0, done}, 32'd0);
    done_cnt = 0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("t4_no_early_done", done_cnt, 32'd0);
    tick();
    chk("t4_done2", {31'd0, done}, 32'd1);
    chk("t4_sum2", {16'd0, sum}, 32'h0003);
    tick();
    chk("t4_done2_once", {31'd0, done}, 32'd0);
    prev_sum = 16'h0003; prev_carry = 1'b0; prev_inv = 1'b0;

    // Reset at the second ADD edge aborts the operation.
    a = 16'h1234; b = 16'h5678; carry_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_sum", {16'd0, sum}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("t5_no_done", done_cnt, 32'd0);
    prev_sum = 16'h0000; prev_carry = 1'b0; prev_inv = 1'b0;
    run_op("t5_after", 16'h0450, 16'h0550, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
Name: bcd_serial_adder_ctrl

Overview:
Sequencing controller that adds two multi-digit packed-BCD operands using one single-digit BCD add stage, time-shared over the digits. It processes one digit per clock, least-significant digit first, and ripples the decimal carry through a register. It uses a start/busy/done handshake, so a multi-digit decimal add can be issued by a host FSM or bench. It sits between a requester and the single-digit BCD adder datapath, and reports non-BCD input digits.

Parameters:
DIGITS, 4, number of BCD digits per operand (legal range 1..16).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  synchronous, active-low reset.
start  input  1  request pulse; sampled only in IDLE.
a  input  4*DIGITS  operand A, packed BCD; digit i = a[4i+3:4i].
b  input  4*DIGITS  operand B, packed BCD.
carry_in  input  1  decimal carry into digit 0.
busy  output  1  high while an add is in progress.
done  output  1  one-cycle completion pulse.
sum  output  4*DIGITS  packed-BCD result; held between operations.
carry  output  1  decimal carry out of the most-significant digit.
invalid  output  1  high if any digit of the latched a or b was greater than 9.

Behaviour:
- Reset is synchronous and active-low. When rst_n is low at a clock edge:
  - state goes to IDLE;
  - busy=0, done=0, sum=0, carry=0, invalid=0;
  - all internal operand, carry and index registers are cleared.
- Reset in the middle of an operation aborts it. No done pulse is produced and the outputs read 0.
- States: IDLE, ADD.
- IDLE, start=1 at edge E0:
  - latch a, b and carry_in into working registers;
  - digit index = 0; working invalid = OR over all digits of (digit > 9);
  - busy goes to 1 and state goes to ADD.
- ADD, edges E1..E_DIGITS: each edge processes the digit at the current index (digit k at edge E(k+1)).
  - s = a_k + b_k + c, computed 5 bits wide, where c is the carry register.
  - If s > 9: digit = (s + 6)[3:0] and c is set to 1. Otherwise: digit = s[3:0] and c is set to 0.
  - The resulting digit is written to working-result position k, and the index increments.
- Non-BCD digits use the same rule, so the result is deterministic. Example: E + 3 + 0 gives digit 7 with carry 1. F + F + 1 gives s = 31, digit 5, carry 1.
- At edge E_DIGITS:
  - the working result is copied to sum, c to carry, and the working invalid flag to invalid;
  - done is set to 1 and busy to 0, and state returns to IDLE.
- Latency: done is high for exactly the one cycle after edge E_DIGITS, i.e. DIGITS edges after the edge that accepted start.
- Outputs sum, carry and invalid change only at completion. They hold their previous values during busy and until the next completion.
- start while busy is ignored: operands are not re-latched and the running operation is unaffected.
- start during the done cycle is accepted (state is IDLE), which gives back-to-back operations with no gap cycle.
- Operand inputs a, b and carry_in need to be stable only at the accepting edge.
- DIGITS=1: done follows one edge after acceptance.

Test Plan:
1. Reset, then DIGITS=4, a=0x1234, b=0x5678, carry_in=0, start pulse → busy for 4 cycles, then done pulse; sum=0x6912, carry=0, invalid=0.
2. a=0x9999, b=0x0001, carry_in=0 → sum=0x0000, carry=1. Then a=0x9999, b=0x9999, carry_in=1 → sum=0x9999, carry=1.
3. a=0x000E, b=0x0003, carry_in=0 → sum=0x0017, carry=0, invalid=1. The next valid operation (0x0003 + 0x0004) → sum=0x0007, invalid=0.
4. Start first op (0x1234 + 0x5678); pulse start with a=0x1111 while busy → first op result (0x6912) is unchanged and only one done is seen. Start asserted in the done cycle with 0x0001 + 0x0002 → second done exactly 4 cycles later, sum=0x0003.
5. Start an op, drive rst_n=0 at the 2nd ADD edge → busy=0 and sum=0 after that edge, and no done ever appears. After release, a new op completes correctly.
6. During busy, check that sum/carry hold the prior result, and that done never asserts for 2 consecutive cycles.
